// File: rtl/pam_symbol_checker.sv
// pam_symbol_checker
//   On-line checker for PAM5 link bring-up. Every valid tx vector goes into a
//   circular history buffer. Each valid decoded vector is compared with the
//   history entry at candidate latency L. While searching, L steps forward on
//   every mismatch until LOCK_THRESH consecutive matches lock it. While locked,
//   vector and error counters accumulate. UNLOCK_THRESH consecutive mismatches
//   drop lock and restart the search from L=0.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | checker disabled; L and run counters held at 0, no compares
//   SEARCH | stepping L on every mismatch, counting consecutive matches
//   LOCKED | L frozen; statistics counters running, counting misses
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   io_enable             low forces IDLE
//   io_txValid/io_txSyms  encoder output tap (channel 0 in the MSBs)
//   io_rxValid/io_rxData  decoder output tap (channel 0 in the MSBs)
//   io_clearCounters      zero both statistics counters on the next edge
//   io_locked             high while in LOCKED
//   io_latency            current candidate or locked latency L
//   io_symCount           vectors compared while locked (saturating)
//   io_errCount           mismatching vectors while locked (saturating)
//   io_errValid/io_errMask registered compare result, errMask MSB = channel 0
module pam_symbol_checker #(
    parameter int NUM_CH        = 4,
    parameter int SYM_W         = 3,
    parameter int MAX_LAT       = 32,
    parameter int CNT_W         = 32,
    parameter int LOCK_THRESH   = 16,
    parameter int UNLOCK_THRESH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        io_enable,
    input  logic                        io_txValid,
    input  logic [NUM_CH*SYM_W-1:0]     io_txSyms,
    input  logic                        io_rxValid,
    input  logic [NUM_CH*SYM_W-1:0]     io_rxData,
    input  logic                        io_clearCounters,
    output logic                        io_locked,
    output logic [$clog2(MAX_LAT)-1:0]  io_latency,
    output logic [CNT_W-1:0]            io_symCount,
    output logic [CNT_W-1:0]            io_errCount,
    output logic                        io_errValid,
    output logic [NUM_CH-1:0]           io_errMask
);

    localparam int LAT_W = $clog2(MAX_LAT);
    localparam int VEC_W = NUM_CH * SYM_W;
    localparam int MR_W  = $clog2(LOCK_THRESH + 1);
    localparam int MS_W  = $clog2(UNLOCK_THRESH + 1);

    localparam logic [LAT_W:0]   FILL_MAX = (LAT_W + 1)'(MAX_LAT);
    localparam logic [MR_W-1:0]  MR_LAST  = MR_W'(LOCK_THRESH - 1);
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(UNLOCK_THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [VEC_W-1:0]  hist [MAX_LAT];
    logic [LAT_W-1:0]  wr_ptr;
    logic [LAT_W:0]    fill;
    logic [LAT_W-1:0]  lat;
    logic [MR_W-1:0]   match_run;
    logic [MS_W-1:0]   miss_run;

    logic [LAT_W-1:0]  rd_idx;
    logic [VEC_W-1:0]  ref_vec;
    logic              ref_ok;
    logic [NUM_CH-1:0] cmp_mask;
    logic              cmp_en;
    logic              cmp_match;

    assign io_latency = lat;

    // wr_ptr points at the next free slot, so age 0 sits one slot behind it.
    // Reading here with the pre-write pointer gives same-cycle tx no effect.
    assign rd_idx  = wr_ptr - LAT_W'(1) - lat;
    assign ref_vec = hist[rd_idx];
    assign ref_ok  = ({1'b0, lat} < fill);
    assign cmp_en  = io_enable && (state != IDLE) && io_rxValid;

    always_comb begin
        cmp_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cmp_mask[i] = !ref_ok ||
                          (io_rxData[i*SYM_W +: SYM_W] != ref_vec[i*SYM_W +: SYM_W]);
        end
    end

    assign cmp_match = (cmp_mask == '0);

    // History contents need no reset: fill gates every read.
    always_ff @(posedge clock) begin
        if (io_txValid) begin
            hist[wr_ptr] <= io_txSyms;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            fill        <= '0;
            lat         <= '0;
            match_run   <= '0;
            miss_run    <= '0;
            io_locked   <= 1'b0;
            io_errValid <= 1'b0;
            io_errMask  <= '0;
            io_symCount <= '0;
            io_errCount <= '0;
        end else begin
            io_errValid <= cmp_en;
            io_errMask  <= cmp_en ? cmp_mask : '0;

            if (io_txValid) begin
                wr_ptr <= wr_ptr + LAT_W'(1);
                if (fill != FILL_MAX) begin
                    fill <= fill + (LAT_W + 1)'(1);
                end
            end

            if (!io_enable) begin
                state     <= IDLE;
                lat       <= '0;
                match_run <= '0;
                miss_run  <= '0;
                io_locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SEARCH;
                    end
                    SEARCH: begin
                        if (io_rxValid) begin
                            if (cmp_match) begin
                                if (match_run == MR_LAST) begin
                                    state     <= LOCKED;
                                    io_locked <= 1'b1;
                                    match_run <= '0;
                                    miss_run  <= '0;
                                end else begin
                                    match_run <= match_run + MR_W'(1);
                                end
                            end else begin
                                match_run <= '0;
                                lat       <= lat + LAT_W'(1);
                            end
                        end
                    end
                    LOCKED: begin
                        if (io_rxValid) begin
                            if (cmp_match) begin
                                miss_run <= '0;
                            end else if (miss_run == MS_LAST) begin
                                state     <= SEARCH;
                                io_locked <= 1'b0;
                                lat       <= '0;
                                match_run <= '0;
                                miss_run  <= '0;
                            end else begin
                                miss_run <= miss_run + MS_W'(1);
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        io_locked <= 1'b0;
                    end
                endcase
            end

            // Clear wins over an increment landing on the same edge.
            if (io_clearCounters) begin
                io_symCount <= '0;
                io_errCount <= '0;
            end else if (cmp_en && (state == LOCKED)) begin
                if (io_symCount != CNT_MAX) begin
                    io_symCount <= io_symCount + CNT_W'(1);
                end
                if (!cmp_match && (io_errCount != CNT_MAX)) begin
                    io_errCount <= io_errCount + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pam_symbol_checker.sv
// Bench for pam_symbol_checker: a queue-based reference model checked against
// the DUT every cycle, plus literal checkpoints for the directed scenarios.
module tb_pam_symbol_checker;

    localparam int NUM_CH  = 4;
    localparam int SYM_W   = 3;
    localparam int MAX_LAT = 32;
    localparam int CNT_W   = 32;
    localparam int LOCK_T  = 16;
    localparam int UNLOCK_T = 8;
    localparam int VEC_W   = NUM_CH * SYM_W;

    logic             clock;
    logic             reset;
    logic             io_enable;
    logic             io_txValid;
    logic [VEC_W-1:0] io_txSyms;
    logic             io_rxValid;
    logic [VEC_W-1:0] io_rxData;
    logic             io_clearCounters;
    logic             io_locked;
    logic [4:0]       io_latency;
    logic [CNT_W-1:0] io_symCount;
    logic [CNT_W-1:0] io_errCount;
    logic             io_errValid;
    logic [NUM_CH-1:0] io_errMask;

    pam_symbol_checker dut (
        .clock           (clock),
        .reset           (reset),
        .io_enable       (io_enable),
        .io_txValid      (io_txValid),
        .io_txSyms       (io_txSyms),
        .io_rxValid      (io_rxValid),
        .io_rxData       (io_rxData),
        .io_clearCounters(io_clearCounters),
        .io_locked       (io_locked),
        .io_latency      (io_latency),
        .io_symCount     (io_symCount),
        .io_errCount     (io_errCount),
        .io_errValid     (io_errValid),
        .io_errMask      (io_errMask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    logic [VEC_W-1:0]  m_hist [$];
    int                m_state = 0;   // 0 idle, 1 search, 2 locked
    int                m_L = 0;
    int                m_mr = 0;
    int                m_miss = 0;
    logic [CNT_W-1:0]  m_sym = '0;
    logic [CNT_W-1:0]  m_err = '0;
    logic              m_ev = 1'b0;
    logic [NUM_CH-1:0] m_mask = '0;

    function automatic logic [SYM_W-1:0] sym_of(input logic [VEC_W-1:0] v, input int c);
        return v[(NUM_CH-1-c)*SYM_W +: SYM_W];
    endfunction

    task automatic model_step();
        logic [VEC_W-1:0] rv;
        bit hit;
        if (reset) begin
            m_hist.delete();
            m_state = 0; m_L = 0; m_mr = 0; m_miss = 0;
            m_sym = '0; m_err = '0; m_ev = 1'b0; m_mask = '0;
            return;
        end
        m_ev = 1'b0;
        m_mask = '0;
        if (!io_enable) begin
            m_state = 0; m_L = 0; m_mr = 0; m_miss = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (io_rxValid) begin
            if (m_L >= m_hist.size()) begin
                m_mask = '1;
            end else begin
                rv = m_hist[m_hist.size() - 1 - m_L];
                for (int c = 0; c < NUM_CH; c++)
                    if (sym_of(io_rxData, c) != sym_of(rv, c)) m_mask[NUM_CH-1-c] = 1'b1;
            end
            m_ev = 1'b1;
            hit = (m_mask == '0);
            if (m_state == 1) begin
                if (hit) begin
                    m_mr++;
                    if (m_mr == LOCK_T) begin m_state = 2; m_mr = 0; m_miss = 0; end
                end else begin
                    m_mr = 0;
                    m_L = (m_L + 1) % MAX_LAT;
                end
            end else begin
                if (m_sym != '1) m_sym = m_sym + 1;
                if (hit) m_miss = 0;
                else begin
                    if (m_err != '1) m_err = m_err + 1;
                    m_miss++;
                    if (m_miss == UNLOCK_T) begin m_state = 1; m_L = 0; m_mr = 0; m_miss = 0; end
                end
            end
        end
        if (io_clearCounters) begin m_sym = '0; m_err = '0; end
        if (io_txValid) begin
            m_hist.push_back(io_txSyms);
            if (m_hist.size() > MAX_LAT) void'(m_hist.pop_front());
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        check("locked",   64'(io_locked),   64'(m_state == 2));
        check("latency",  64'(io_latency),  64'(m_L));
        check("symCount", 64'(io_symCount), 64'(m_sym));
        check("errCount", 64'(io_errCount), 64'(m_err));
        check("errValid", 64'(io_errValid), 64'(m_ev));
        check("errMask",  64'(io_errMask),  64'(m_mask));
    end

    // ---------------- stimulus ----------------
    int               d = 5;
    bit               seq_mode = 1'b1;
    int               k = 0;
    bit               corrupt = 1'b0;
    logic [VEC_W-1:0] log_d [$];
    bit               log_v [$];

    function automatic logic [VEC_W-1:0] seq_vec(input int n);
        logic [VEC_W-1:0] v;
        int p;
        v = '0;
        p = 1;
        for (int c = 0; c < NUM_CH; c++) begin
            v[(NUM_CH-1-c)*SYM_W +: SYM_W] = SYM_W'(((n / p) % 5) - 2);
            p = p * 5;
        end
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++)
            v[c*SYM_W +: SYM_W] = SYM_W'(int'($urandom_range(0, 4)) - 2);
        return v;
    endfunction

    task automatic step(input bit txv);
        logic [VEC_W-1:0] txd;
        logic [VEC_W-1:0] rxd;
        txd = seq_mode ? seq_vec(k) : rand_vec();
        k++;
        io_txValid = txv;
        io_txSyms  = txd;
        if (log_d.size() >= d) begin
            rxd = log_d[log_d.size() - d];
            if (corrupt) rxd[5:3] = rxd[5:3] + 3'd1;
            io_rxValid = log_v[log_v.size() - d];
            io_rxData  = rxd;
        end else begin
            io_rxValid = 1'b0;
            io_rxData  = '0;
        end
        @(posedge clock);
        log_v.push_back(txv);
        log_d.push_back(txd);
        if (log_d.size() > 64) begin
            void'(log_d.pop_front());
            void'(log_v.pop_front());
        end
        @(negedge clock);
    endtask

    task automatic wait_lock(input bit want, input int budget, input string name);
        int n;
        n = 0;
        while (io_locked !== want && n < budget) begin
            step(1'b1);
            n++;
        end
        vectors++;
        if (io_locked !== want) begin
            miscompares++;
            $display("FAIL %s: io_locked=%0b, wanted %0b within %0d cycles", name, io_locked, want, budget);
        end
    endtask

    initial begin
        logic [CNT_W-1:0] s0;
        logic [CNT_W-1:0] e0;
        reset = 1'b1;
        io_enable = 1'b0;
        io_clearCounters = 1'b0;
        io_txValid = 1'b0;
        io_txSyms = '0;
        io_rxValid = 1'b0;
        io_rxData = '0;
        step(1'b1);
        step(1'b1);
        check("rst_locked", 64'(io_locked), 64'd0);
        check("rst_latency", 64'(io_latency), 64'd0);
        check("rst_symCount", 64'(io_symCount), 64'd0);
        check("rst_errValid", 64'(io_errValid), 64'd0);

        // 1: rx = tx through 5 registers
        reset = 1'b0;
        io_enable = 1'b1;
        d = 5;
        wait_lock(1'b1, 300, "t1_lock");
        check("t1_latency", 64'(io_latency), 64'd4);
        check("t1_errCount", 64'(io_errCount), 64'd0);
        s0 = io_symCount;
        repeat (10) step(1'b1);
        check("t1_symGrowth", 64'(io_symCount - s0), 64'd10);

        // 3: single corrupted channel 2
        corrupt = 1'b1;
        step(1'b1);
        corrupt = 1'b0;
        check("t3_errValid", 64'(io_errValid), 64'd1);
        check("t3_errMask", 64'(io_errMask), 64'b0010);
        check("t3_errCount", 64'(io_errCount), 64'd1);
        repeat (3) step(1'b1);
        check("t3_locked", 64'(io_locked), 64'd1);

        // 4: delay 5 -> 9
        d = 9;
        wait_lock(1'b0, 20, "t4_unlock");
        check("t4_errAtUnlock", 64'(io_errCount), 64'd9);
        wait_lock(1'b1, 300, "t4_relock");
        check("t4_latency", 64'(io_latency), 64'd8);
        check("t4_errHold", 64'(io_errCount), 64'd9);

        // 5: clear together with a mismatch
        repeat (4) step(1'b1);
        corrupt = 1'b1;
        io_clearCounters = 1'b1;
        step(1'b1);
        corrupt = 1'b0;
        io_clearCounters = 1'b0;
        check("t5_symCount", 64'(io_symCount), 64'd0);
        check("t5_errCount", 64'(io_errCount), 64'd0);
        check("t5_locked", 64'(io_locked), 64'd1);

        // 2: random symbols, delay 20, search restarted through IDLE
        seq_mode = 1'b0;
        d = 20;
        io_enable = 1'b0;
        step(1'b1);
        io_enable = 1'b1;
        s0 = io_symCount;
        e0 = io_errCount;
        wait_lock(1'b1, 400, "t2_lock");
        check("t2_latency", 64'(io_latency), 64'd19);
        check("t2_symHold", 64'(io_symCount), 64'(s0));
        check("t2_errHold", 64'(io_errCount), 64'(e0));
        repeat (5) step(1'b1);

        // 6: reset while locked, then delay 2
        seq_mode = 1'b1;
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        d = 2;
        check("t6_locked", 64'(io_locked), 64'd0);
        check("t6_latency", 64'(io_latency), 64'd0);
        check("t6_symCount", 64'(io_symCount), 64'd0);
        check("t6_errCount", 64'(io_errCount), 64'd0);
        check("t6_errValid", 64'(io_errValid), 64'd0);
        check("t6_errMask", 64'(io_errMask), 64'd0);
        wait_lock(1'b1, 300, "t6_relock");
        check("t6_latency_lock", 64'(io_latency), 64'd1);

        // random traffic: gaps, delay changes, clears, corruption, enable drops
        seq_mode = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) d = int'($urandom_range(1, 20));
            io_enable = ($urandom_range(0, 99) >= 2);
            io_clearCounters = ($urandom_range(0, 99) < 3);
            corrupt = ($urandom_range(0, 99) < 5);
            step($urandom_range(0, 99) < 85);
        end
        corrupt = 1'b0;
        io_clearCounters = 1'b0;
        step(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
